rpu_lif_array: RTL and testbench
================================

Name: rpu_lif_array

Overview:
- Multi-channel leaky integrate-and-fire (LIF) neuron array for the neuromorphic RPU.
- Parametrised successor to the single-channel sensor-to-motor path: NUM_CH sensor channels, configurable leak, threshold and refractory period.
- Population spike-count over a sample window produces a saturated motor command with a valid strobe.
- Sits between the sensor front-end (sample + data_valid) and the motor driver.

Parameters:
- DATA_W, 8, sensor sample width and motor_command width.
- NUM_CH, 4, number of neuron channels.
- POT_W, 12, membrane potential width; unsigned, saturating.
- THRESHOLD, 200, firing threshold; must be < 2^POT_W.
- LEAK_SHIFT, 3, leak per sample = pot >> LEAK_SHIFT.
- REFRAC_CYCLES, 2, accepted samples ignored after a spike (0 = none).
- WINDOW, 4, accepted samples per motor-command window (>= 1).
- CMD_GAIN, 16, motor_command = spike_count * CMD_GAIN, saturated.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse; arms or re-arms the array.
- sensor_data, input, NUM_CH*DATA_W, channel i at bits [i*DATA_W +: DATA_W].
- data_valid, input, 1, sample strobe; one sample accepted per high cycle.
- spike, output, NUM_CH, per-channel one-cycle spike pulse.
- motor_command, output, DATA_W, registered population command.
- cmd_valid, output, 1, one-cycle pulse when motor_command updates.
- busy, output, 1, high in RUN.

Behaviour:
- Reset (rst=0, async): state=IDLE; all potentials, refractory counters, window counter and spike accumulator = 0; spike=0, motor_command=0, cmd_valid=0, busy=0.
- FSM IDLE: busy=0; data_valid ignored. start=1 -> RUN next edge.
- FSM RUN: busy=1. start=1 in RUN clears potentials, refractory counters, window counter and accumulator and stays in RUN. motor_command holds its value. A simultaneous data_valid is dropped.
- Sample accepted = RUN && data_valid && !start.
- Per channel, on an accepted sample, if refractory counter = 0:
  - new = sat(pot - (pot >> LEAK_SHIFT) + in), saturating at 2^POT_W-1.
  - If new >= THRESHOLD: fire; pot <- 0; refractory counter <- REFRAC_CYCLES.
  - Otherwise pot <- new.
- Per channel, on an accepted sample, if refractory counter != 0: input ignored; pot stays 0; counter decrements.
- No leak or update on cycles without an accepted sample.
- spike[i] is registered and high for exactly the one cycle following the accepting edge; it is 0 otherwise.
- Window counter increments per accepted sample. The accumulator adds popcount(fires) for the same sample. Accumulator width is clog2(NUM_CH*WINDOW+1).
- On the WINDOW-th accepted sample (edge E), the window closes:
  - At E+1: motor_command <- min(total*CMD_GAIN, 2^DATA_W-1), where total includes fires from sample E.
  - cmd_valid is high during the cycle after E+1.
  - Counter and accumulator restart at 0; a sample accepted at E+1 counts toward the new window.
- Latency: spike 1 cycle after the accepting edge; motor_command / cmd_valid 2 cycles after it.
- Back-to-back data_valid on every cycle is fully supported.

Optional Feature:
- Macro RPU_WTA_EN: winner-take-all lateral inhibition.
- Defined: among channels that would fire on a sample, only the one with the highest new potential fires (ties go to the lowest index). Losers have pot <- 0 and no refractory load. At most one spike bit is set per sample.
- Undefined: every channel crossing threshold fires independently.

Test Plan:
- Reset, start, ch0=55 every sample, others 0 -> ch0 potential 55,104,146,183. spike[0] pulses after the 5th sample (216 >= 200). No other spikes.
- ch1=100 per sample -> spike[1] on sample 3 (100,188,265). Samples 4-5 ignored (pot 0). Sample 6 gives pot 100.
- All channels=250, WINDOW=4, WTA off -> spikes on samples 1 and 4 on all channels. motor_command=128 (8*16), cmd_valid one cycle, 2 cycles after sample 4.
- Same stimulus with RPU_WTA_EN -> winners ch0, ch1, ch2, ch0 on samples 1-4. motor_command=64.
- REFRAC_CYCLES=0, all channels=255 -> 16 spikes per window. motor_command saturates to 255.
- Assert rst low mid-window with pot nonzero -> all outputs 0 immediately (async). data_valid with no start -> no spike, busy=0. start during RUN -> potentials and window cleared, motor_command retained.

Source files
------------

// File: rtl/rpu_lif_array_if.sv
// Sensor-in / spike-and-motor-out bundle for rpu_lif_array.
// master drives samples and start; slave (the neuron array) drives spikes, command and status.
interface rpu_lif_array_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
);
  logic                     start;
  logic [NUM_CH*DATA_W-1:0] sensor_data;
  logic                     data_valid;
  logic [NUM_CH-1:0]        spike;
  logic [DATA_W-1:0]        motor_command;
  logic                     cmd_valid;
  logic                     busy;

  modport master (
    output start, sensor_data, data_valid,
    input  spike, motor_command, cmd_valid, busy
  );

  modport slave (
    input  start, sensor_data, data_valid,
    output spike, motor_command, cmd_valid, busy
  );
endinterface

// File: rtl/rpu_lif_array.sv
// Multi-channel leaky integrate-and-fire array producing a windowed, saturated motor command.
// Define RPU_WTA_EN to enable winner-take-all lateral inhibition between channels.
module rpu_lif_array #(
  parameter int DATA_W        = 8,
  parameter int NUM_CH        = 4,
  parameter int POT_W         = 12,
  parameter int THRESHOLD     = 200,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRAC_CYCLES = 2,
  parameter int WINDOW        = 4,
  parameter int CMD_GAIN      = 16
) (
  input  logic           clk,
  input  logic           rst,
  rpu_lif_array_if.slave bus
);
  localparam int ACC_W  = $clog2(NUM_CH*WINDOW+1);
  localparam int RC_W   = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES+1) : 1;
  localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int SUM_W  = ((POT_W > DATA_W) ? POT_W : DATA_W) + 1;
  localparam int GAIN_W = (CMD_GAIN > 0) ? $clog2(CMD_GAIN+1) : 1;
  localparam int PROD_W = ((ACC_W+GAIN_W) > DATA_W) ? (ACC_W+GAIN_W) : (DATA_W+1);

  localparam logic [POT_W-1:0]  POT_MAX   = '1;
  localparam logic [POT_W-1:0]  THRESH    = POT_W'(THRESHOLD);
  localparam logic [RC_W-1:0]   REFRAC_LD = RC_W'(REFRAC_CYCLES);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW-1);
  localparam logic [GAIN_W-1:0] GAIN      = GAIN_W'(CMD_GAIN);
  localparam logic [DATA_W-1:0] CMD_MAX   = '1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [POT_W-1:0]  pot_q    [NUM_CH];
  logic [POT_W-1:0]  pot_d    [NUM_CH];
  logic [RC_W-1:0]   refrac_q [NUM_CH];
  logic [RC_W-1:0]   refrac_d [NUM_CH];
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  total_q, total_d;
  logic              close_q, close_d;
  logic [NUM_CH-1:0] spike_q, spike_d;
  logic [DATA_W-1:0] cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;

  logic [NUM_CH-1:0][POT_W-1:0] new_pot;
  logic [NUM_CH-1:0]            cand_fire;
  logic [NUM_CH-1:0]            fire_vec;
  logic [ACC_W-1:0]             fire_cnt;
  logic [ACC_W-1:0]             acc_sum;
  logic [PROD_W-1:0]            prod;
  logic [DATA_W-1:0]            cmd_sat;
  logic                         accept;

  // Leak, integrate and saturate every channel in parallel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [POT_W-1:0] leaked;
    logic [SUM_W-1:0] sum;

    assign leaked        = pot_q[gi] - (pot_q[gi] >> LEAK_SHIFT);
    assign sum           = SUM_W'(leaked) + SUM_W'(bus.sensor_data[gi*DATA_W +: DATA_W]);
    assign new_pot[gi]   = (sum > SUM_W'(POT_MAX)) ? POT_MAX : sum[POT_W-1:0];
    assign cand_fire[gi] = (refrac_q[gi] == '0) && (new_pot[gi] >= THRESH);
  end

`ifdef RPU_WTA_EN
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [POT_W-1:0] win_pot;

  // Strict '>' keeps the lowest index on equal potentials.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_pot   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cand_fire[i] && (!win_found || (new_pot[i] > win_pot))) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_pot   = new_pot[i];
      end
    end
    fire_vec = '0;
    if (win_found) begin
      fire_vec[win_idx] = 1'b1;
    end
  end
`else
  assign fire_vec = cand_fire;
`endif

  always_comb begin
    fire_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fire_cnt = fire_cnt + ACC_W'(fire_vec[i]);
    end
  end

  assign acc_sum = acc_q + fire_cnt;
  assign prod    = PROD_W'(total_q) * PROD_W'(GAIN);
  assign cmd_sat = (prod > PROD_W'(CMD_MAX)) ? CMD_MAX : prod[DATA_W-1:0];
  assign accept  = (state_q == ST_RUN) && bus.data_valid && !bus.start;

  always_comb begin
    state_d     = state_q;
    pot_d       = pot_q;
    refrac_d    = refrac_q;
    win_cnt_d   = win_cnt_q;
    acc_d       = acc_q;
    total_d     = total_q;
    close_d     = 1'b0;
    spike_d     = '0;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;

    // A window closed last edge is scored now, even if start arrives meanwhile.
    if (close_q) begin
      cmd_d       = cmd_sat;
      cmd_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
    endcase

    if (bus.start) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pot_d[i]    = '0;
        refrac_d[i] = '0;
      end
      win_cnt_d = '0;
      acc_d     = '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (refrac_q[i] != '0) begin
          refrac_d[i] = refrac_q[i] - 1'b1;
          pot_d[i]    = '0;
        end else if (cand_fire[i]) begin
          // Winners and inhibited losers both discharge; only winners go refractory.
          pot_d[i] = '0;
          if (fire_vec[i]) begin
            refrac_d[i] = REFRAC_LD;
          end
        end else begin
          pot_d[i] = new_pot[i];
        end
      end
      spike_d = fire_vec;
      if (win_cnt_q == WIN_LAST) begin
        win_cnt_d = '0;
        acc_d     = '0;
        total_d   = acc_sum;
        close_d   = 1'b1;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        acc_d     = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NUM_CH; i++) begin
        pot_q[i]    <= '0;
        refrac_q[i] <= '0;
      end
      win_cnt_q   <= '0;
      acc_q       <= '0;
      total_q     <= '0;
      close_q     <= 1'b0;
      spike_q     <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pot_q       <= pot_d;
      refrac_q    <= refrac_d;
      win_cnt_q   <= win_cnt_d;
      acc_q       <= acc_d;
      total_q     <= total_d;
      close_q     <= close_d;
      spike_q     <= spike_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign bus.spike         = spike_q;
  assign bus.motor_command = cmd_q;
  assign bus.cmd_valid     = cmd_valid_q;
  assign bus.busy          = (state_q == ST_RUN);
endmodule

// File: tb/tb_rpu_lif_array.sv
// Scoreboard bench for rpu_lif_array: default instance plus a REFRAC_CYCLES=0 instance.
// Expected spikes/commands are queued with the cycle they must appear on; a negedge monitor checks them.
module tb_rpu_lif_array;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

`ifdef RPU_WTA_EN
  localparam bit WTA = 1'b1;
`else
  localparam bit WTA = 1'b0;
`endif

  rpu_lif_array_if #(.DATA_W(8), .NUM_CH(4)) bus ();
  rpu_lif_array_if #(.DATA_W(8), .NUM_CH(4)) bus_z ();

  rpu_lif_array dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rpu_lif_array #(.REFRAC_CYCLES(0)) dut_z (
    .clk (clk),
    .rst (rst),
    .bus (bus_z)
  );

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t sq[$];
  exp_t cq[$];
  exp_t sqz[$];
  exp_t cqz[$];

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pop expectations due this cycle, otherwise the output must be quiet.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      if (sq.size() != 0 && sq[0].cyc == cyc) begin
        e = sq.pop_front();
        $display("txn spike   dut   cyc=%0d got=%b exp=%b", cyc, bus.spike, e.val[3:0]);
        check("spike", 32'(bus.spike), e.val);
      end else begin
        check("spike_idle", 32'(bus.spike), 32'd0);
      end
      if (cq.size() != 0 && cq[0].cyc == cyc) begin
        e = cq.pop_front();
        $display("txn command dut   cyc=%0d got=%0d valid=%b exp=%0d", cyc, bus.motor_command, bus.cmd_valid, e.val);
        check("cmd_valid", 32'(bus.cmd_valid), 32'd1);
        check("motor_command", 32'(bus.motor_command), e.val);
      end else begin
        check("cmd_valid_idle", 32'(bus.cmd_valid), 32'd0);
      end
      if (sqz.size() != 0 && sqz[0].cyc == cyc) begin
        e = sqz.pop_front();
        $display("txn spike   dut_z cyc=%0d got=%b exp=%b", cyc, bus_z.spike, e.val[3:0]);
        check("z_spike", 32'(bus_z.spike), e.val);
      end else begin
        check("z_spike_idle", 32'(bus_z.spike), 32'd0);
      end
      if (cqz.size() != 0 && cqz[0].cyc == cyc) begin
        e = cqz.pop_front();
        $display("txn command dut_z cyc=%0d got=%0d valid=%b exp=%0d", cyc, bus_z.motor_command, bus_z.cmd_valid, e.val);
        check("z_cmd_valid", 32'(bus_z.cmd_valid), 32'd1);
        check("z_motor_command", 32'(bus_z.motor_command), e.val);
      end else begin
        check("z_cmd_valid_idle", 32'(bus_z.cmd_valid), 32'd0);
      end
    end
  end

  task automatic drive(input bit z, input bit st, input bit dv, input logic [31:0] data);
    if (z) begin
      bus_z.start       = st;
      bus_z.data_valid  = dv;
      bus_z.sensor_data = data;
    end else begin
      bus.start       = st;
      bus.data_valid  = dv;
      bus.sensor_data = data;
    end
  endtask

  // One accepted sample; spike due next cycle, command (if any) the cycle after.
  task automatic sample(input bit z, input logic [7:0] c0, input logic [7:0] c1,
                        input logic [7:0] c2, input logic [7:0] c3,
                        input logic [3:0] spk, input int cmd);
    exp_t e;
    @(negedge clk);
    drive(z, 1'b0, 1'b1, {c3, c2, c1, c0});
    e.cyc = cyc + 1;
    e.val = 32'(spk);
    if (z) sqz.push_back(e); else sq.push_back(e);
    if (cmd >= 0) begin
      e.cyc = cyc + 2;
      e.val = 32'(cmd);
      if (z) cqz.push_back(e); else cq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0);
    end
  endtask

  task automatic start_pulse(input bit z, input bit dv, input logic [31:0] data);
    @(negedge clk);
    drive(z, 1'b1, dv, data);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_spike", 32'(bus.spike), 32'd0);
    check("rst_cmd", 32'(bus.motor_command), 32'd0);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_z_busy", 32'(bus_z.busy), 32'd0);
    check("rst_z_cmd", 32'(bus_z.motor_command), 32'd0);
    rst = 1'b1;

    // data_valid while IDLE is ignored
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, {4{8'd250}});
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    idle(2);

    start_pulse(1'b0, 1'b0, 32'd0);
    idle(1);
    check("run_busy", 32'(bus.busy), 32'd1);

    // All channels at 250: fire on samples 1 and 4 (WTA: ch0, ch1, ch2, ch0)
    sample(1'b0, 250, 250, 250, 250, WTA ? 4'b0001 : 4'b1111, -1);
    sample(1'b0, 250, 250, 250, 250, WTA ? 4'b0010 : 4'b0000, -1);
    sample(1'b0, 250, 250, 250, 250, WTA ? 4'b0100 : 4'b0000, -1);
    sample(1'b0, 250, 250, 250, 250, WTA ? 4'b0001 : 4'b1111, WTA ? 64 : 128);
    idle(3);

    // start in RUN keeps the command; charge some potential then clear it again
    start_pulse(1'b0, 1'b0, 32'd0);
    idle(1);
    check("cmd_hold_1", 32'(bus.motor_command), WTA ? 32'd64 : 32'd128);
    check("busy_after_restart", 32'(bus.busy), 32'd1);
    sample(1'b0, 55, 100, 0, 0, 4'b0000, -1);
    sample(1'b0, 55, 100, 0, 0, 4'b0000, -1);
    start_pulse(1'b0, 1'b0, 32'd0);
    idle(1);
    check("cmd_hold_2", 32'(bus.motor_command), WTA ? 32'd64 : 32'd128);

    // ch0=55: 55,104,146,183,216 -> fires s5; ch1=100: 100,188,265 -> fires s3, s4-5 refractory, s6 100
    sample(1'b0, 55, 100, 0, 0, 4'b0000, -1);
    sample(1'b0, 55, 100, 0, 0, 4'b0000, -1);
    idle(2);
    sample(1'b0, 55, 100, 0, 0, 4'b0010, -1);
    sample(1'b0, 55, 100, 0, 0, 4'b0000, 16);
    sample(1'b0, 55, 100, 0, 0, 4'b0001, -1);
    sample(1'b0, 55, 100, 0, 0, 4'b0000, -1);
    sample(1'b0, 55, 100, 0, 0, 4'b0000, -1);
    sample(1'b0, 55, 100, 0, 0, 4'b0010, 32);
    idle(3);

    // start with simultaneous data_valid drops that sample; threshold edge 200 fires, 199 does not
    start_pulse(1'b0, 1'b1, {4{8'd250}});
    sample(1'b0, 0, 199, 150, 200, 4'b1000, -1);
    sample(1'b0, 0, 0, 150, 0, 4'b0100, -1);
    sample(1'b0, 0, 0, 150, 0, 4'b0000, -1);
    sample(1'b0, 0, 0, 150, 0, 4'b0000, 32);
    idle(3);

    // Asynchronous reset mid-window while a spike is showing
    start_pulse(1'b0, 1'b0, 32'd0);
    sample(1'b0, 100, 0, 0, 180, 4'b0000, -1);
    sample(1'b0, 100, 0, 0, 50, 4'b1000, -1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("async_spike", 32'(bus.spike), 32'd0);
    check("async_cmd", 32'(bus.motor_command), 32'd0);
    check("async_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("async_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, {4{8'd250}});
    repeat (2) @(negedge clk);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    idle(2);

    // Potentials and window restart from zero after reset: 100,188,265
    start_pulse(1'b0, 1'b0, 32'd0);
    sample(1'b0, 100, 0, 0, 0, 4'b0000, -1);
    sample(1'b0, 100, 0, 0, 0, 4'b0000, -1);
    sample(1'b0, 100, 0, 0, 0, 4'b0001, -1);
    sample(1'b0, 100, 0, 0, 0, 4'b0000, 16);
    idle(3);

    // No refractory period: 16 spikes per window saturate the command
    start_pulse(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      sample(1'b1, 255, 255, 255, 255, WTA ? 4'b0001 : 4'b1111,
             (i == 3) ? (WTA ? 64 : 255) : -1);
    end
    idle(4);

    check("spike_queue_drained", 32'(sq.size() + sqz.size()), 32'd0);
    check("cmd_queue_drained", 32'(cq.size() + cqz.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
